// File: rtl/layer_pkg.sv
// Shared types and sizes for the VGA layer compositor: layer count, priority
// width, effects FSM states and the priority table layout.
package layer_pkg;

    localparam int LAYERS      = 8;
    localparam int PRIO_W      = 3;
    localparam int LAYER_IDX_W = $clog2(LAYERS);

    typedef enum logic [1:0] {IDLE, BLINK, FLASH} fx_state_t;

    typedef logic [LAYERS-1:0][PRIO_W-1:0] prio_tbl_t;
    typedef logic [LAYERS-1:0][7:0]        rgb_bus_t;

    // Power-up order: layer i has priority i, so layer 0 is on top.
    function automatic prio_tbl_t reset_prio();
        prio_tbl_t t;
        for (int i = 0; i < LAYERS; i++) t[i] = PRIO_W'(i);
        return t;
    endfunction

    // A config index is only valid when it names an existing layer.
    function automatic logic layer_ok(input logic [LAYER_IDX_W-1:0] idx);
        return {1'b0, idx} < (LAYER_IDX_W+1)'(LAYERS);
    endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// Pixel, configuration and effect-event signals of the layer sequencer.
// The master side feeds layers and config; the slave side is the compositor.
interface layer_sequencer_if;
    import layer_pkg::*;

    logic                   startOfFrame;
    logic [LAYERS-1:0]      layerDR;
    rgb_bus_t               layerRGB;
    logic [7:0]             backGroundRGB;
    logic                   cfgWrEn;
    logic [LAYER_IDX_W-1:0] cfgLayer;
    logic [PRIO_W-1:0]      cfgPrio;
    logic                   cfgEn;
    logic                   hitEvent;
    logic                   winEvent;
    logic [7:0]             RGBOut;
    logic [LAYER_IDX_W-1:0] selLayer;
    logic                   selValid;
    logic                   fxActive;

    modport master (
        output startOfFrame, layerDR, layerRGB, backGroundRGB,
               cfgWrEn, cfgLayer, cfgPrio, cfgEn, hitEvent, winEvent,
        input  RGBOut, selLayer, selValid, fxActive
    );

    modport slave (
        input  startOfFrame, layerDR, layerRGB, backGroundRGB,
               cfgWrEn, cfgLayer, cfgPrio, cfgEn, hitEvent, winEvent,
        output RGBOut, selLayer, selValid, fxActive
    );

endinterface

// File: rtl/layer_prio_select.sv
// Combinational winner finder: among candidate layers, the minimum priority
// value wins and equal priorities resolve to the lower layer index.
module layer_prio_select
    import layer_pkg::*;
(
    input  logic [LAYERS-1:0]      cand,
    input  prio_tbl_t              prio,
    output logic [LAYER_IDX_W-1:0] winIdx,
    output logic                   anyWin
);

    logic [PRIO_W-1:0] bestPrio;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        winIdx   = '0;
        anyWin   = 1'b0;
        bestPrio = '1;
        // Strict '<' keeps the earlier (lower) index on a priority tie.
        for (int i = 0; i < LAYERS; i++) begin
            if (cand[i] && (!anyWin || prio[i] < bestPrio)) begin
                anyWin   = 1'b1;
                bestPrio = prio[i];
                winIdx   = LAYER_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// Priority pixel compositor with frame-synchronous table swap and a
// blink/flash effects FSM; all outputs come from one register stage.
module layer_sequencer
    import layer_pkg::*;
#(
    parameter int          HIT_LAYER     = 0,
    parameter int          BLINK_FRAMES  = 4,
    parameter int          BLINK_TOGGLES = 6,
    parameter int          FLASH_FRAMES  = 30,
    parameter logic [7:0]  FLASH_RGB     = 8'hFF
) (
    input logic               clk,
    input logic               resetN,
    layer_sequencer_if.slave  bus
);

    localparam int MAX_BT  = (BLINK_FRAMES > BLINK_TOGGLES) ? BLINK_FRAMES : BLINK_TOGGLES;
    localparam int CNT_MAX = (FLASH_FRAMES > MAX_BT) ? FLASH_FRAMES : MAX_BT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    prio_tbl_t         shPrio, shPrioNxt, actPrio;
    logic [LAYERS-1:0] shEn, shEnNxt, actEn;

    fx_state_t         state, stateNxt;
    logic [CNT_W-1:0]  frameCnt, frameCntNxt, toggleCnt, toggleCntNxt;
    logic              hideHit, hideHitNxt, flashOn, flashOnNxt;

    logic [LAYERS-1:0]      hitMask, cand;
    logic [LAYER_IDX_W-1:0] winIdx;
    logic                   anyWin;
    logic [7:0]             rgbQ;
    logic [LAYER_IDX_W-1:0] selQ;
    logic                   validQ;

    // A write in the same clock as startOfFrame must land in the copy, so the
    // active tables load from the post-write shadow value.
    always_comb begin
        shPrioNxt = shPrio;
        shEnNxt   = shEn;
        if (bus.cfgWrEn && layer_ok(bus.cfgLayer)) begin
            shPrioNxt[bus.cfgLayer] = bus.cfgPrio;
            shEnNxt[bus.cfgLayer]   = bus.cfgEn;
        end
    end

    // NOTE: the tables are a handful of flops with defined power-up contents, so they sit on reset like any other state.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            shPrio  <= reset_prio();
            actPrio <= reset_prio();
            shEn    <= '1;
            actEn   <= '1;
        end else begin
            shPrio <= shPrioNxt;
            shEn   <= shEnNxt;
            if (bus.startOfFrame) begin
                actPrio <= shPrioNxt;
                actEn   <= shEnNxt;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            frameCnt  <= '0;
            toggleCnt <= '0;
            hideHit   <= 1'b0;
            flashOn   <= 1'b0;
        end else begin
            state     <= stateNxt;
            frameCnt  <= frameCntNxt;
            toggleCnt <= toggleCntNxt;
            hideHit   <= hideHitNxt;
            flashOn   <= flashOnNxt;
        end
    end

    // Events outrank the frame tick, so an event on startOfFrame only loads entry values.
    always_comb begin
        stateNxt     = state;
        frameCntNxt  = frameCnt;
        toggleCntNxt = toggleCnt;
        hideHitNxt   = hideHit;
        flashOnNxt   = flashOn;
        case (state)
            IDLE: begin
                if (bus.winEvent) begin
                    stateNxt    = FLASH;
                    flashOnNxt  = 1'b1;
                    frameCntNxt = '0;
                end else if (bus.hitEvent) begin
                    stateNxt     = BLINK;
                    hideHitNxt   = 1'b1;
                    frameCntNxt  = '0;
                    toggleCntNxt = '0;
                end
            end
            BLINK: begin
                if (bus.winEvent) begin
                    stateNxt     = FLASH;
                    hideHitNxt   = 1'b0;
                    flashOnNxt   = 1'b1;
                    frameCntNxt  = '0;
                    toggleCntNxt = '0;
                end else if (bus.hitEvent) begin
                    hideHitNxt   = 1'b1;
                    frameCntNxt  = '0;
                    toggleCntNxt = '0;
                end else if (bus.startOfFrame) begin
                    if (frameCnt == CNT_W'(BLINK_FRAMES - 1)) begin
                        frameCntNxt  = '0;
                        hideHitNxt   = ~hideHit;
                        toggleCntNxt = toggleCnt + CNT_W'(1);
                        if (toggleCnt == CNT_W'(BLINK_TOGGLES - 1)) begin
                            stateNxt     = IDLE;
                            hideHitNxt   = 1'b0;
                            toggleCntNxt = '0;
                        end
                    end else begin
                        frameCntNxt = frameCnt + CNT_W'(1);
                    end
                end
            end
            FLASH: begin
                if (bus.startOfFrame) begin
                    if (frameCnt == CNT_W'(FLASH_FRAMES - 1)) begin
                        stateNxt    = IDLE;
                        flashOnNxt  = 1'b0;
                        frameCntNxt = '0;
                    end else begin
                        flashOnNxt  = ~flashOn;
                        frameCntNxt = frameCnt + CNT_W'(1);
                    end
                end
            end
            default: stateNxt = IDLE;
        endcase
    end

    assign hitMask = hideHit ? (LAYERS'(1) << HIT_LAYER) : '0;
    assign cand    = bus.layerDR & actEn & ~hitMask;

    layer_prio_select u_select (
        .cand   (cand),
        .prio   (actPrio),
        .winIdx (winIdx),
        .anyWin (anyWin)
    );

    // selLayer only moves when a layer actually wins.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rgbQ   <= '0;
            selQ   <= '0;
            validQ <= 1'b0;
        end else if (flashOn) begin
            rgbQ   <= FLASH_RGB;
            validQ <= 1'b0;
        end else if (anyWin) begin
            rgbQ   <= bus.layerRGB[winIdx];
            selQ   <= winIdx;
            validQ <= 1'b1;
        end else begin
            rgbQ   <= bus.backGroundRGB;
            validQ <= 1'b0;
        end
    end

    assign bus.RGBOut   = rgbQ;
    assign bus.selLayer = selQ;
    assign bus.selValid = validQ;
    assign bus.fxActive = (state != IDLE);

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: a frame-count reference model pushes
// the expected registered pixel per clock, popped and compared after the edge.
module tb_layer_sequencer;
    import layer_pkg::*;

    localparam int FRAME_LEN   = 4;
    localparam int HIT         = 0;
    localparam int BLINK_HALF  = 4;
    localparam int BLINK_TOTAL = 24;
    localparam int FLASH_TOTAL = 30;

    typedef struct packed {
        logic       fx;
        logic       valid;
        logic [2:0] sel;
        logic [7:0] rgb;
    } out_t;

    logic clk = 1'b0;
    logic resetN;
    always #5 clk = ~clk;

    layer_sequencer_if bus ();

    layer_sequencer dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    out_t sbq[$];
    int   nChecks = 0;
    int   nFails  = 0;

    int   mShPrio[LAYERS], mActPrio[LAYERS];
    bit   mShEn[LAYERS], mActEn[LAYERS];
    int   mMode;   // 0 idle, 1 blink, 2 flash
    int   mFr;     // frames counted since the effect started
    int   mSel;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < LAYERS; i++) begin
            mShPrio[i] = i; mActPrio[i] = i; mShEn[i] = 1'b1; mActEn[i] = 1'b1;
        end
        mMode = 0; mFr = 0; mSel = 0;
    endtask

    task automatic model_advance();
        if (bus.cfgWrEn) begin
            mShPrio[bus.cfgLayer] = bus.cfgPrio;
            mShEn[bus.cfgLayer]   = bus.cfgEn;
        end
        if (bus.startOfFrame)
            for (int i = 0; i < LAYERS; i++) begin
                mActPrio[i] = mShPrio[i]; mActEn[i] = mShEn[i];
            end
        case (mMode)
            0: if (bus.winEvent) begin mMode = 2; mFr = 0; end
               else if (bus.hitEvent) begin mMode = 1; mFr = 0; end
            1: if (bus.winEvent) begin mMode = 2; mFr = 0; end
               else if (bus.hitEvent) mFr = 0;
               else if (bus.startOfFrame) begin
                   mFr++;
                   if (mFr == BLINK_TOTAL) mMode = 0;
               end
            default: if (bus.startOfFrame) begin
                   mFr++;
                   if (mFr == FLASH_TOTAL) mMode = 0;
               end
        endcase
    endtask

    // One clock: predict the registered outputs, clock, compare, drop pulses.
    task automatic step(input string tag);
        out_t e, got;
        bit   hide, flash, found;
        int   w;
        hide  = (mMode == 1) && (((mFr / BLINK_HALF) % 2) == 0);
        flash = (mMode == 2) && ((mFr % 2) == 0);
        found = 1'b0;
        w     = 0;
        for (int p = 0; p < (1 << PRIO_W); p++)
            for (int i = 0; i < LAYERS; i++)
                if (!found && bus.layerDR[i] && mActEn[i] && !(hide && i == HIT) && mActPrio[i] == p) begin
                    found = 1'b1; w = i;
                end
        e = '0;
        if (flash) begin
            e.rgb = 8'hFF; e.valid = 1'b0;
        end else if (found) begin
            e.rgb = bus.layerRGB[w]; e.valid = 1'b1; mSel = w;
        end else begin
            e.rgb = bus.backGroundRGB; e.valid = 1'b0;
        end
        e.sel = 3'(mSel);
        model_advance();
        e.fx = (mMode != 0);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        got = {bus.fxActive, bus.selValid, bus.selLayer, bus.RGBOut};
        e = sbq.pop_front();
        check(tag, 32'(got), 32'(e));
        bus.startOfFrame = 1'b0;
        bus.cfgWrEn      = 1'b0;
        bus.hitEvent     = 1'b0;
        bus.winEvent     = 1'b0;
    endtask

    task automatic run_frames(input int n, input string tag);
        for (int f = 0; f < n; f++)
            for (int c = 0; c < FRAME_LEN; c++) begin
                if (c == 0) bus.startOfFrame = 1'b1;
                step(tag);
            end
    endtask

    task automatic cfg_write(input int layer, input int prio, input bit en, input bit sof, input string tag);
        bus.cfgWrEn      = 1'b1;
        bus.cfgLayer     = 3'(layer);
        bus.cfgPrio      = 3'(prio);
        bus.cfgEn        = en;
        bus.startOfFrame = sof;
        step(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        resetN           = 1'b0;
        bus.startOfFrame = 1'b0;
        bus.layerDR      = '0;
        bus.backGroundRGB = 8'h5A;
        bus.cfgWrEn      = 1'b0;
        bus.cfgLayer     = '0;
        bus.cfgPrio      = '0;
        bus.cfgEn        = 1'b0;
        bus.hitEvent     = 1'b0;
        bus.winEvent     = 1'b0;
        for (int i = 0; i < LAYERS; i++) bus.layerRGB[i] = 8'(8'h11 * (i + 1));
        model_reset();
        #12;
        check("reset_out", 32'({bus.fxActive, bus.selValid, bus.selLayer, bus.RGBOut}), 32'd0);
        @(negedge clk);
        resetN = 1'b1;

        // Default order: layers 1 and 2 request, layer 1 wins.
        bus.layerDR = 8'b0000_0110;
        step("dr_0110");

        // Shadow write stays invisible until the frame swap.
        cfg_write(2, 0, 1'b1, 1'b0, "cfg_prio2");
        step("shadow_only");
        bus.startOfFrame = 1'b1;
        step("sof_swap");
        step("prio2_active");

        // Same-clock write is included in the swap; then tie and disable.
        bus.layerDR = 8'b0010_1000;
        cfg_write(3, 1, 1'b1, 1'b0, "cfg_prio3");
        cfg_write(5, 0, 1'b1, 1'b1, "cfg_prio5_sof");
        step("prio5_wins");
        cfg_write(5, 1, 1'b1, 1'b1, "cfg_tie_sof");
        step("tie_low_index");
        cfg_write(3, 1, 1'b0, 1'b1, "cfg_dis3_sof");
        step("en3_off");

        // No requests: background, selLayer holds.
        bus.layerDR = 8'h00;
        step("background_a");
        step("background_b");

        // Blink on the hit layer, restarted mid-sequence, run to completion.
        bus.layerDR  = 8'b0000_0011;
        step("pre_blink");
        bus.hitEvent = 1'b1;
        run_frames(10, "blink_a");
        bus.hitEvent = 1'b1;
        run_frames(26, "blink_b");
        check("blink_done", 32'(bus.fxActive), 32'd0);

        // Blink interrupted by a win; hit and win ignored during flash.
        bus.hitEvent = 1'b1;
        run_frames(5, "blink_c");
        bus.winEvent = 1'b1;
        run_frames(3, "flash_a");
        bus.hitEvent = 1'b1;
        bus.winEvent = 1'b1;
        run_frames(30, "flash_b");
        check("flash_done", 32'(bus.fxActive), 32'd0);

        // Reset in the middle of a flash aborts everything at once.
        bus.winEvent = 1'b1;
        run_frames(7, "flash_c");
        step("flash_mid");
        resetN = 1'b0;
        #2;
        check("rst_rgb", 32'(bus.RGBOut), 32'd0);
        check("rst_sel", 32'(bus.selLayer), 32'd0);
        check("rst_valid", 32'(bus.selValid), 32'd0);
        check("rst_fx", 32'(bus.fxActive), 32'd0);
        model_reset();
        sbq.delete();
        @(negedge clk);
        resetN = 1'b1;
        bus.layerDR = 8'b0010_1000;
        step("post_rst_tables");
        bus.layerDR = 8'b0000_0001;
        step("post_rst_idle");

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule
